// File: rtl/y86_fetch_queue.sv
// y86_fetch_queue: Y86-64 fetch front end with a circular prefetch byte queue
// feeding a one-entry decoded-instruction output register.
module y86_fetch_queue #(
    parameter int FETCH_BYTES = 4,
    parameter int QUEUE_BYTES = 16,
    parameter int IMEM_BYTES  = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect_valid,
    input  logic [63:0]              redirect_pc,
    output logic                     imem_rd,
    output logic [63:0]              imem_addr,
    input  logic [8*FETCH_BYTES-1:0] imem_rdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2:0]               out_stat,
    output logic [3:0]               out_icode,
    output logic [3:0]               out_ifun,
    output logic [3:0]               out_rA,
    output logic [3:0]               out_rB,
    output logic [63:0]              out_valC,
    output logic [63:0]              out_valP,
    output logic [63:0]              out_pc
);
    localparam int IW = $clog2(QUEUE_BYTES);
    localparam int CW = $clog2(QUEUE_BYTES + 1);
    localparam logic [2:0] AOK = 3'd1, HLT = 3'd2, ADR = 3'd3, INS = 3'd4;

    typedef enum logic {RUN, STOPPED} state_t;
    state_t state, state_next;

    logic [7:0]             q_data [QUEUE_BYTES];
    logic [QUEUE_BYTES-1:0] q_err;
    logic [IW-1:0]          head, tail;
    logic [CW-1:0]          count;
    logic                   inflight;
    logic [63:0]            inflight_addr, fetch_pc, pc;

    logic [7:0]  pk [10];
    logic [9:0]  pk_err;
    logic [3:0]  icode, len;
    logic        has_reg, ins, consumed_err, push, pop, space_ok;
    logic [1:0]  c_base;
    logic [63:0] dec_valC;
    logic [2:0]  dec_stat;

    function automatic logic [IW-1:0] wrap(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        return IW'(s >= QUEUE_BYTES ? s - QUEUE_BYTES : s);
    endfunction

    always_comb begin
        for (int i = 0; i < 10; i++) begin
            pk[i]     = q_data[wrap(head, i)];
            pk_err[i] = q_err[wrap(head, i)];
        end
    end

    // c_base selects where valC starts: 2 -> bytes 2..9, 1 -> bytes 1..8, 0 -> none
    always_comb begin
        icode   = pk[0][7:4];
        len     = 4'd1;
        has_reg = 1'b0;
        ins     = 1'b0;
        c_base  = 2'd0;
        case (icode)
            4'h0, 4'h1, 4'h9:       len = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB: begin len = 4'd2; has_reg = 1'b1; end
            4'h3, 4'h4, 4'h5:       begin len = 4'd10; has_reg = 1'b1; c_base = 2'd2; end
            4'h7, 4'h8:             begin len = 4'd9; c_base = 2'd1; end
            default:                ins = 1'b1;
        endcase
        if (pk_err[0]) begin
            len     = 4'd1;
            has_reg = 1'b0;
            c_base  = 2'd0;
        end
        consumed_err = 1'b0;
        for (int i = 0; i < 10; i++) consumed_err |= pk_err[i] && (i < int'(len));
        dec_valC = '0;
        for (int j = 0; j < 8; j++)
            dec_valC[8*j +: 8] = c_base == 2'd2 ? pk[j+2] : c_base == 2'd1 ? pk[j+1] : 8'h00;
        dec_stat = consumed_err ? ADR : ins ? INS : icode == 4'h0 ? HLT : AOK;
    end

    // Space check ignores a same-cycle pop, so the queue can never overflow.
    assign space_ok  = int'(count) + (inflight ? FETCH_BYTES : 0) + FETCH_BYTES <= QUEUE_BYTES;
    assign imem_rd   = !rst && state == RUN && !redirect_valid && space_ok;
    assign imem_addr = fetch_pc;
    assign push      = inflight && !redirect_valid;
    assign pop       = state == RUN && !redirect_valid && count >= CW'(len) && (!out_valid || out_ready);

    always_comb begin
        state_next = state;
        if (redirect_valid) state_next = RUN;
        else if (pop && dec_stat != AOK) state_next = STOPPED;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            for (int k = 0; k < FETCH_BYTES; k++) begin
                q_data[wrap(tail, k)] <= imem_rdata[8*k +: 8];
                q_err[wrap(tail, k)]  <= 65'(inflight_addr) + 65'(k) >= 65'(IMEM_BYTES);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= RUN;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            inflight      <= 1'b0;
            inflight_addr <= '0;
            fetch_pc      <= '0;
            pc            <= '0;
            out_valid     <= 1'b0;
            out_stat      <= AOK;
            out_icode     <= '0;
            out_ifun      <= '0;
            out_rA        <= 4'hF;
            out_rB        <= 4'hF;
            out_valC      <= '0;
            out_valP      <= '0;
            out_pc        <= '0;
        end else begin
            state         <= state_next;
            inflight      <= imem_rd;
            inflight_addr <= fetch_pc;
            if (redirect_valid) begin
                head      <= '0;
                tail      <= '0;
                count     <= '0;
                fetch_pc  <= redirect_pc;
                pc        <= redirect_pc;
                out_valid <= 1'b0;
            end else begin
                if (imem_rd) fetch_pc <= fetch_pc + 64'(FETCH_BYTES);
                if (push) tail <= wrap(tail, FETCH_BYTES);
                count <= count + (push ? CW'(FETCH_BYTES) : CW'(0)) - (pop ? CW'(len) : CW'(0));
                if (pop) begin
                    head      <= wrap(head, int'(len));
                    pc        <= pc + 64'(len);
                    out_valid <= 1'b1;
                    out_stat  <= dec_stat;
                    out_icode <= icode;
                    out_ifun  <= pk[0][3:0];
                    out_rA    <= has_reg ? pk[1][7:4] : 4'hF;
                    out_rB    <= has_reg ? pk[1][3:0] : 4'hF;
                    out_valC  <= dec_valC;
                    out_valP  <= pc + 64'(len);
                    out_pc    <= pc;
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: doc/y86_fetch_queue.md
Name: y86_fetch_queue

Overview:
- Next-generation Y86-64 fetch front end with a parametrised prefetch byte queue. Issues wide reads to instruction memory and aligns variable-length Y86 instructions out of the queue.
- Presents one fully decoded instruction per cycle to decode over a valid/ready handshake.
- Supports a redirect/flush from execute (jump, call, ret, mispredict) and stops on halt or error.
- Sits between instruction memory and the decode stage of the pipelined CPU.

Parameters:
- FETCH_BYTES, 4, bytes returned per imem read (≥1).
- QUEUE_BYTES, 16, byte queue capacity (≥10 and ≥2*FETCH_BYTES).
- IMEM_BYTES, 1024, instruction memory size; any byte address ≥ IMEM_BYTES is an address error.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- redirect_valid  in  1  flush queue and restart fetch at redirect_pc.
- redirect_pc  in  64  new fetch PC.
- imem_rd  out  1  read request this cycle.
- imem_addr  out  64  byte address of the request.
- imem_rdata  in  8*FETCH_BYTES  byte k = bits [8k+7:8k] = mem[addr+k]; valid exactly one cycle after the request.
- out_valid  out  1  decoded instruction available.
- out_ready  in  1  decode accepts the instruction.
- out_stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS.
- out_icode, out_ifun, out_rA, out_rB  out  4 each.
- out_valC  out  64  little-endian constant.
- out_valP  out  64  pc + length.
- out_pc  out  64  address of the instruction.

Behaviour:
- Reset (async): queue empty, in-flight cleared, fetch_pc=0, state RUN, imem_rd=0, imem_addr=0, out_valid=0, out_stat=1, out_rA=out_rB=4'hF, all other outputs 0. First imem_rd is in the first cycle after rst deasserts.
- Request rule: in RUN, assert imem_rd with imem_addr=fetch_pc when count + inflight_bytes + FETCH_BYTES ≤ QUEUE_BYTES. A same-cycle pop is ignored for this check (conservative). After issuing, fetch_pc += FETCH_BYTES. No alignment requirement.
- Response: the cycle after a request, push FETCH_BYTES entries. Each entry is 8 data bits plus an err flag; err is set if addr+k ≥ IMEM_BYTES.
- Queue: circular buffer with head, tail and count; wraps modulo QUEUE_BYTES. Push and variable-size pop may occur in the same cycle; the count update must be exact. Overflow is impossible by the request rule.
- Length by head icode:
  - 0, 1, 9 → 1 byte.
  - 2, 6, A, B → 2 bytes.
  - 3, 4, 5 → 10 bytes.
  - 7, 8 → 9 bytes.
  - Other icodes → 1 byte, stat INS.
- Field extraction:
  - rA/rB come from byte 1 when present, else 4'hF.
  - valC = bytes 2..9 for icodes 3/4/5, bytes 1..8 for icodes 7/8, else 0.
  - valP = pc + length; pc is tracked internally and advances by length on each pop.
- Pop condition: count ≥ length and the output register is free (!out_valid || out_ready). The decoded result loads into the output register on that edge (one-cycle decode latency).
- Status:
  - icode 0 → HLT.
  - Any consumed byte with err set → ADR, which overrides INS/HLT.
  - If the head byte itself has err set, length is 1 and stat is ADR.
  - Otherwise AOK.
- State machine:
  - RUN → STOPPED when a non-AOK instruction is popped.
  - STOPPED: no requests and no further pops; the output register still completes its handshake.
  - STOPPED → RUN only on redirect.
- Output hold: while out_valid && !out_ready, all out_* are stable.
- Redirect has the highest priority and acts on the edge where redirect_valid=1:
  - Queue cleared, out_valid←0, fetch_pc and pc ← redirect_pc, state RUN.
  - Any response arriving the next cycle is discarded.
  - No request is issued in the redirect cycle; the first new request is in the following cycle.
  - A handshake (out_valid && out_ready) in the redirect cycle is void; decode must drop it.
- Reset asserted mid-operation returns all state to the reset values immediately, including discarding in-flight data.

Test Plan:
- Reset, imem holds 30 F1 0C 00 00 00 00 00 00 00 then 00 at address 10, out_ready=1 → requests at addr 0,4,8,…; first out: icode 3, rA F, rB 1, valC 12, pc 0, valP 10, stat 1; next out: icode 0, stat 2, pc 10, valP 11; then imem_rd stays 0.
- Stream of 16 nop bytes (10) with out_ready=0 → requests stop once count+inflight would exceed 16; no data lost. Release ready → 16 consecutive outs, pc 0..15, one per cycle.
- Byte FF at address 5 after nops → 5 AOK nops, then icode F, stat 4, pc 5; fetching stops.
- IMEM_BYTES=1024, redirect_pc=1020, bytes 30 F1 at 1020..1021 → one out, stat 3, pc 1020.
- Redirect to 40 while out_valid=1, out_ready=1, and a response in flight → stale response dropped; the next out has pc 40 with correct fields.
- rst pulsed mid-stream for a partial cycle → out_valid drops asynchronously; after release, fetch restarts at addr 0.
